// File: rtl/l1d_mshr_rsp_ctrl.sv
// l1d_mshr_rsp_ctrl
//   Response-side end of the L1D MSHR downstream interface. Linefill read
//   beats are assembled into a full cache line, presented to the data pipe
//   and retired with linefill_done_en/id. Evict write acks are retired
//   directly with evict_done_en/id, independently of the linefill path.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rsp_vld/rsp_rdy       downstream response beat handshake
//   rsp_type              0 = linefill read data, 1 = evict write ack
//   rsp_id/data/last/err  response beat payload
//   lf_wr_vld/rdy         assembled line handshake to the data pipe
//   lf_wr_id/data/err     owning MSHR id, assembled line, OR of beat errors
//   linefill_done_en/id   one-cycle linefill retire pulse
//   evict_done_en/id      one-cycle evict retire pulse
//   proto_err             sticky protocol-violation flag
module l1d_mshr_rsp_ctrl #(
  parameter int L1D_MSHR_ID_WIDTH = 3,
  parameter int BEAT_WIDTH        = 128,
  parameter int BEATS_PER_LINE    = 4,
  parameter int LINE_WIDTH        = BEAT_WIDTH * BEATS_PER_LINE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rsp_vld,
  output logic                         rsp_rdy,
  input  logic                         rsp_type,
  input  logic [L1D_MSHR_ID_WIDTH-1:0] rsp_id,
  input  logic [BEAT_WIDTH-1:0]        rsp_data,
  input  logic                         rsp_last,
  input  logic                         rsp_err,
  output logic                         lf_wr_vld,
  input  logic                         lf_wr_rdy,
  output logic [L1D_MSHR_ID_WIDTH-1:0] lf_wr_id,
  output logic [LINE_WIDTH-1:0]        lf_wr_data,
  output logic                         lf_wr_err,
  output logic                         linefill_done_en,
  output logic [L1D_MSHR_ID_WIDTH-1:0] linefill_done_id,
  output logic                         evict_done_en,
  output logic [L1D_MSHR_ID_WIDTH-1:0] evict_done_id,
  output logic                         proto_err
);

  localparam int CNT_W = $clog2(BEATS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]             cnt_reg;
  logic [L1D_MSHR_ID_WIDTH-1:0] id_reg;
  logic                         err_acc_reg;
  logic [BEAT_WIDTH-1:0]        line_buf_reg [BEATS_PER_LINE];
  logic                         lf_done_en_reg;
  logic [L1D_MSHR_ID_WIDTH-1:0] lf_done_id_reg;
  logic                         ev_done_en_reg;
  logic [L1D_MSHR_ID_WIDTH-1:0] ev_done_id_reg;
  logic                         proto_err_reg;

  logic                         rd_acc;
  logic                         ack_acc;
  logic                         final_beat;
  logic                         lf_hs;
  logic                         viol;
  logic [BEATS_PER_LINE-1:0]    beat_we;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lf_wr_vld  = 1'b0;
    // Acks are always welcome; read beats stall only while a line is
    // waiting for the data pipe. Gated by rst_n so nothing is taken in reset.
    rsp_rdy    = rst_n & (rsp_type | (state_reg != WRITE));
    case (state_reg)
      IDLE: begin
        if (rd_acc) state_next = COLLECT;
      end
      COLLECT: begin
        if (rd_acc && (cnt_reg == LAST_CNT)) state_next = WRITE;
      end
      WRITE: begin
        lf_wr_vld = 1'b1;
        if (lf_wr_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_acc  = rsp_vld & rsp_rdy & ~rsp_type;
  assign ack_acc = rsp_vld & rsp_rdy &  rsp_type;
  assign lf_hs   = (state_reg == WRITE) & lf_wr_rdy;

  // The counter alone decides completion; rsp_last is only cross-checked.
  // In IDLE cnt_reg is 0, so a first beat is never the final one.
  assign final_beat = (state_reg == COLLECT) && (cnt_reg == LAST_CNT);

  assign viol = (rd_acc  & (rsp_last != final_beat))
              | (rd_acc  & (state_reg == COLLECT) & (rsp_id != id_reg))
              | (ack_acc & rsp_err & ~rsp_last);

  // ---------------------------------------------------------------------------
  // Line assembly: one write enable per beat slot, selected by the counter
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_slot
      assign beat_we[gi] = rd_acc && (cnt_reg == CNT_W'(gi));
      assign lf_wr_data[gi*BEAT_WIDTH +: BEAT_WIDTH] = line_buf_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BEATS_PER_LINE; i++) begin
        line_buf_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BEATS_PER_LINE; i++) begin
        if (beat_we[i]) line_buf_reg[i] <= rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      id_reg      <= '0;
      err_acc_reg <= 1'b0;
    end else begin
      if (rd_acc) begin
        // Wraps to 0 naturally on the final beat.
        cnt_reg <= cnt_reg + 1'b1;
        if (state_reg == IDLE) begin
          id_reg      <= rsp_id;
          err_acc_reg <= rsp_err;
        end else begin
          // A mismatching id is flagged but the owner of the line is kept.
          err_acc_reg <= err_acc_reg | rsp_err;
        end
      end else if (lf_hs) begin
        cnt_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retire pulses and sticky protocol error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_done_en_reg <= 1'b0;
      lf_done_id_reg <= '0;
      ev_done_en_reg <= 1'b0;
      ev_done_id_reg <= '0;
      proto_err_reg  <= 1'b0;
    end else begin
      lf_done_en_reg <= lf_hs;
      if (lf_hs) lf_done_id_reg <= id_reg;
      ev_done_en_reg <= ack_acc;
      if (ack_acc) ev_done_id_reg <= rsp_id;
      if (viol) proto_err_reg <= 1'b1;
    end
  end

  assign lf_wr_id         = id_reg;
  assign lf_wr_err        = err_acc_reg;
  assign linefill_done_en = lf_done_en_reg;
  assign linefill_done_id = lf_done_id_reg;
  assign evict_done_en    = ev_done_en_reg;
  assign evict_done_id    = ev_done_id_reg;
  assign proto_err        = proto_err_reg;

endmodule

// File: tb/tb_l1d_mshr_rsp_ctrl.sv
// Directed testbench for l1d_mshr_rsp_ctrl: line assembly, backpressure,
// simultaneous retire, error accumulation, ack errors, protocol violations
// and reset in the middle of a line.
module tb_l1d_mshr_rsp_ctrl;

  localparam int IW = 3;
  localparam int BW = 128;
  localparam int NB = 4;
  localparam int LW = 512;

  logic          clk;
  logic          rst_n;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic          rsp_type;
  logic [IW-1:0] rsp_id;
  logic [BW-1:0] rsp_data;
  logic          rsp_last;
  logic          rsp_err;
  logic          lf_wr_vld;
  logic          lf_wr_rdy;
  logic [IW-1:0] lf_wr_id;
  logic [LW-1:0] lf_wr_data;
  logic          lf_wr_err;
  logic          linefill_done_en;
  logic [IW-1:0] linefill_done_id;
  logic          evict_done_en;
  logic [IW-1:0] evict_done_id;
  logic          proto_err;

  int total = 0;
  int bad   = 0;

  l1d_mshr_rsp_ctrl #(
    .L1D_MSHR_ID_WIDTH(IW),
    .BEAT_WIDTH(BW),
    .BEATS_PER_LINE(NB),
    .LINE_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy),
    .rsp_type(rsp_type),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_last(rsp_last),
    .rsp_err(rsp_err),
    .lf_wr_vld(lf_wr_vld),
    .lf_wr_rdy(lf_wr_rdy),
    .lf_wr_id(lf_wr_id),
    .lf_wr_data(lf_wr_data),
    .lf_wr_err(lf_wr_err),
    .linefill_done_en(linefill_done_en),
    .linefill_done_id(linefill_done_id),
    .evict_done_en(evict_done_en),
    .evict_done_id(evict_done_id),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [LW-1:0] mk_line(input logic [7:0] b);
    return {mk_beat(b + 8'd3), mk_beat(b + 8'd2), mk_beat(b + 8'd1), mk_beat(b)};
  endfunction

  // Called just after a rising edge; returns just after the edge that
  // transferred the beat.
  task automatic send_beat(input logic typ, input logic [IW-1:0] id, input logic [BW-1:0] d,
                           input logic last, input logic err);
    int n;
    rsp_vld  = 1'b1;
    rsp_type = typ;
    rsp_id   = id;
    rsp_data = d;
    rsp_last = last;
    rsp_err  = err;
    n = 0;
    @(negedge clk);
    while (!rsp_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", rsp_rdy, 1'b1);
    @(posedge clk);
    #1;
    rsp_vld  = 1'b0;
    rsp_last = 1'b0;
    rsp_err  = 1'b0;
    rsp_type = 1'b0;
  endtask

  task automatic send_line(input logic [IW-1:0] id, input logic [7:0] base,
                           input logic [NB-1:0] errm, input logic [NB-1:0] lastm);
    for (int i = 0; i < NB; i++) begin
      send_beat(1'b0, id, mk_beat(base + 8'(i)), lastm[i], errm[i]);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rsp_vld = 1'b0;
    #1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_vld   = 1'b0;
    rsp_type  = 1'b1;
    rsp_id    = '0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    lf_wr_rdy = 1'b1;

    // ---- reset state ----
    #12;
    check("rst_rdy_ack", rsp_rdy, 1'b0);
    check("rst_lf_vld", lf_wr_vld, 1'b0);
    check("rst_lf_data", lf_wr_data, '0);
    check("rst_lf_id", lf_wr_id, '0);
    check("rst_lf_err", lf_wr_err, 1'b0);
    check("rst_lf_done", linefill_done_en, 1'b0);
    check("rst_ev_done", evict_done_en, 1'b0);
    check("rst_proto", proto_err, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    rsp_type = 1'b0;
    @(negedge clk);
    check("idle_rd_rdy", rsp_rdy, 1'b1);
    sync();

    // ---- line assembly ----
    send_line(3'd5, 8'hA0, 4'b0000, 4'b1000);
    @(negedge clk);
    check("asm_vld", lf_wr_vld, 1'b1);
    check("asm_data", lf_wr_data, mk_line(8'hA0));
    check("asm_id", lf_wr_id, 3'd5);
    check("asm_err", lf_wr_err, 1'b0);
    @(negedge clk);
    check("asm_done_en", linefill_done_en, 1'b1);
    check("asm_done_id", linefill_done_id, 3'd5);
    check("asm_vld_drop", lf_wr_vld, 1'b0);
    @(negedge clk);
    check("asm_done_once", linefill_done_en, 1'b0);
    check("asm_proto", proto_err, 1'b0);
    sync();

    // ---- backpressure ----
    lf_wr_rdy = 1'b0;
    send_line(3'd5, 8'hA0, 4'b0000, 4'b1000);
    @(negedge clk);
    check("bp_vld", lf_wr_vld, 1'b1);
    check("bp_data", lf_wr_data, mk_line(8'hA0));
    rsp_vld  = 1'b1;
    rsp_type = 1'b0;
    rsp_id   = 3'd2;
    rsp_data = mk_beat(8'hB0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_rd_blocked", rsp_rdy, 1'b0);
      check("bp_hold_data", lf_wr_data, mk_line(8'hA0));
    end
    sync();
    rsp_type = 1'b1;
    rsp_id   = 3'd3;
    @(negedge clk);
    check("bp_ack_rdy", rsp_rdy, 1'b1);
    sync();
    rsp_vld = 1'b0;
    @(negedge clk);
    check("bp_ev_en", evict_done_en, 1'b1);
    check("bp_ev_id", evict_done_id, 3'd3);
    check("bp_hold_vld", lf_wr_vld, 1'b1);
    check("bp_hold_id", lf_wr_id, 3'd5);
    check("bp_hold_data2", lf_wr_data, mk_line(8'hA0));
    sync();
    lf_wr_rdy = 1'b1;
    rsp_vld   = 1'b1;
    rsp_type  = 1'b0;
    rsp_id    = 3'd2;
    rsp_data  = mk_beat(8'hB0);
    rsp_last  = 1'b0;
    @(negedge clk);
    check("bp_hs_rd_blocked", rsp_rdy, 1'b0);
    check("bp_ev_once", evict_done_en, 1'b0);
    @(negedge clk);
    check("bp_done_en", linefill_done_en, 1'b1);
    check("bp_done_id", linefill_done_id, 3'd5);
    check("bp_rd_rdy_again", rsp_rdy, 1'b1);
    sync();
    rsp_vld = 1'b0;
    for (int i = 1; i < NB; i++) begin
      send_beat(1'b0, 3'd2, mk_beat(8'hB0 + 8'(i)), (i == NB - 1), 1'b0);
    end
    @(negedge clk);
    check("bp_l2_id", lf_wr_id, 3'd2);
    check("bp_l2_data", lf_wr_data, mk_line(8'hB0));
    @(negedge clk);
    check("bp_l2_done", linefill_done_en, 1'b1);
    check("bp_l2_done_id", linefill_done_id, 3'd2);
    sync();

    // ---- simultaneous retire ----
    lf_wr_rdy = 1'b0;
    send_line(3'd4, 8'hC0, 4'b0000, 4'b1000);
    rsp_vld   = 1'b1;
    rsp_type  = 1'b1;
    rsp_id    = 3'd1;
    lf_wr_rdy = 1'b1;
    @(negedge clk);
    check("sim_ack_rdy", rsp_rdy, 1'b1);
    sync();
    rsp_vld = 1'b0;
    @(negedge clk);
    check("sim_lf_en", linefill_done_en, 1'b1);
    check("sim_lf_id", linefill_done_id, 3'd4);
    check("sim_ev_en", evict_done_en, 1'b1);
    check("sim_ev_id", evict_done_id, 3'd1);
    sync();

    // ---- error accumulation ----
    send_line(3'd3, 8'hD0, 4'b0100, 4'b1000);
    @(negedge clk);
    check("err_lf_err", lf_wr_err, 1'b1);
    check("err_proto_clean", proto_err, 1'b0);
    sync();

    // ---- ack errors and back-to-back acks ----
    rsp_vld  = 1'b1;
    rsp_type = 1'b1;
    rsp_id   = 3'd2;
    rsp_err  = 1'b1;
    rsp_last = 1'b1;
    sync();
    rsp_id  = 3'd4;
    rsp_err = 1'b0;
    @(negedge clk);
    check("ack_b2b_en0", evict_done_en, 1'b1);
    check("ack_b2b_id0", evict_done_id, 3'd2);
    sync();
    rsp_vld = 1'b0;
    @(negedge clk);
    check("ack_b2b_en1", evict_done_en, 1'b1);
    check("ack_b2b_id1", evict_done_id, 3'd4);
    check("ack_err_last_ok", proto_err, 1'b0);
    @(negedge clk);
    check("ack_b2b_end", evict_done_en, 1'b0);
    sync();
    send_beat(1'b1, 3'd5, '0, 1'b0, 1'b1);
    @(negedge clk);
    check("ack_err_nolast", proto_err, 1'b1);
    check("ack_err_ev_id", evict_done_id, 3'd5);
    sync();

    // ---- early rsp_last ----
    do_reset();
    check("early_proto_rst", proto_err, 1'b0);
    send_beat(1'b0, 3'd6, mk_beat(8'hE0), 1'b0, 1'b0);
    send_beat(1'b0, 3'd6, mk_beat(8'hE1), 1'b1, 1'b0);
    @(negedge clk);
    check("early_proto", proto_err, 1'b1);
    check("early_not_closed", lf_wr_vld, 1'b0);
    sync();
    send_beat(1'b0, 3'd6, mk_beat(8'hE2), 1'b0, 1'b0);
    send_beat(1'b0, 3'd6, mk_beat(8'hE3), 1'b1, 1'b0);
    @(negedge clk);
    check("early_vld", lf_wr_vld, 1'b1);
    check("early_data", lf_wr_data, mk_line(8'hE0));
    check("early_err", lf_wr_err, 1'b0);
    sync();

    // ---- id mismatch ----
    do_reset();
    send_beat(1'b0, 3'd0, mk_beat(8'h10), 1'b0, 1'b0);
    send_beat(1'b0, 3'd0, mk_beat(8'h11), 1'b0, 1'b0);
    @(negedge clk);
    check("idm_proto_pre", proto_err, 1'b0);
    sync();
    send_beat(1'b0, 3'd6, mk_beat(8'h12), 1'b0, 1'b0);
    @(negedge clk);
    check("idm_proto", proto_err, 1'b1);
    sync();
    send_beat(1'b0, 3'd0, mk_beat(8'h13), 1'b1, 1'b0);
    @(negedge clk);
    check("idm_id", lf_wr_id, 3'd0);
    check("idm_data", lf_wr_data, mk_line(8'h10));
    @(negedge clk);
    check("idm_done_id", linefill_done_id, 3'd0);
    sync();

    // ---- reset mid-line ----
    do_reset();
    send_beat(1'b0, 3'd1, mk_beat(8'h50), 1'b0, 1'b0);
    send_beat(1'b0, 3'd1, mk_beat(8'h51), 1'b0, 1'b0);
    rst_n    = 1'b0;
    rsp_type = 1'b1;
    #1;
    check("mid_rst_rdy", rsp_rdy, 1'b0);
    check("mid_rst_data", lf_wr_data, '0);
    check("mid_rst_id", lf_wr_id, '0);
    check("mid_rst_vld", lf_wr_vld, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    rsp_type = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_done", linefill_done_en, 1'b0);
    end
    sync();
    send_line(3'd7, 8'h70, 4'b0000, 4'b1000);
    @(negedge clk);
    check("mid_l7_data", lf_wr_data, mk_line(8'h70));
    check("mid_l7_id", lf_wr_id, 3'd7);
    @(negedge clk);
    check("mid_l7_done", linefill_done_en, 1'b1);
    check("mid_l7_done_id", linefill_done_id, 3'd7);
    check("mid_l7_proto", proto_err, 1'b0);
    sync();

    // ---- missing rsp_last on the final beat ----
    send_line(3'd2, 8'h80, 4'b0000, 4'b0000);
    @(negedge clk);
    check("nolast_closed", lf_wr_vld, 1'b1);
    check("nolast_proto", proto_err, 1'b1);
    sync();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1d_mshr_rsp_ctrl.md
Name: l1d_mshr_rsp_ctrl

Overview:
- Response-side end of the MSHR downstream request interface: consumes responses from the downstream (L2/bus) port.
- Linefill read data arrives as BEATS_PER_LINE beats and is assembled into a full line, written to the data pipe, then retired with linefill_done_en/id.
- Evict write acks are retired directly as evict_done_en/id.
- Sits between the downstream response channel and the MSHR/data pipe.

Parameters:
- L1D_MSHR_ID_WIDTH, 3, MSHR id width (8 entries).
- BEAT_WIDTH, 128, response data bits per beat.
- BEATS_PER_LINE, 4, beats per cache line; must be ≥2 and a power of 2.
- LINE_WIDTH, 512, equals BEAT_WIDTH*BEATS_PER_LINE.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- rsp_vld  in  1  response beat valid.
- rsp_rdy  out  1  response beat ready.
- rsp_type  in  1  0 = linefill read data, 1 = evict write ack.
- rsp_id  in  L1D_MSHR_ID_WIDTH  MSHR id of the response.
- rsp_data  in  BEAT_WIDTH  beat data; ignored for acks.
- rsp_last  in  1  final beat marker.
- rsp_err  in  1  beat error (bus/ECC).
- lf_wr_vld  out  1  assembled line valid to the data pipe.
- lf_wr_rdy  in  1  data pipe ready.
- lf_wr_id  out  L1D_MSHR_ID_WIDTH  owning MSHR id.
- lf_wr_data  out  LINE_WIDTH  assembled line.
- lf_wr_err  out  1  OR of rsp_err over all beats of the line.
- linefill_done_en  out  1  one-cycle linefill retire pulse.
- linefill_done_id  out  L1D_MSHR_ID_WIDTH  retiring id.
- evict_done_en  out  1  one-cycle evict retire pulse.
- evict_done_id  out  L1D_MSHR_ID_WIDTH  retiring id.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, beat count = 0.
  - lf_wr_vld, linefill_done_en, evict_done_en, proto_err, lf_wr_err = 0.
  - ids = 0, line buffer = 0.
  - rsp_rdy = 0 while rst_n is low.
- Handshake: a beat transfers when rsp_vld & rsp_rdy. rsp_rdy is combinational from state and rsp_type only, never from rsp_vld:
  - read beat ready when state is IDLE or COLLECT;
  - ack ready in every state after reset.
- FSM transitions:
  - IDLE, read beat accepted: store the beat at bits [0 +: BEAT_WIDTH], latch rsp_id, cnt = 1, err_acc = rsp_err, go COLLECT.
  - COLLECT, read beat accepted: store at [cnt*BEAT_WIDTH +: BEAT_WIDTH], cnt++, OR rsp_err into err_acc. On the beat with cnt == BEATS_PER_LINE-1, go WRITE.
  - WRITE: lf_wr_vld = 1; lf_wr_data, lf_wr_id and lf_wr_err are stable while lf_wr_vld is high and lf_wr_rdy is low. On lf_wr_vld & lf_wr_rdy: go IDLE, cnt = 0; the next cycle, linefill_done_en = 1 for exactly one cycle with linefill_done_id = latched id.
- Read beats are not accepted in the handshake cycle of WRITE. The first beat of the next line is accepted at the earliest one cycle later. Back-to-back line throughput is therefore BEATS_PER_LINE+1 cycles.
- Completion is decided by the beat counter only. proto_err is set (sticky until reset) when:
  - rsp_last=1 on a non-final beat (line not closed);
  - rsp_last=0 on the final beat (line still closed);
  - a COLLECT read beat has rsp_id ≠ latched id (beat still stored; the latched id is kept).
- Ack: when an ack is accepted, the next cycle evict_done_en = 1 for one cycle with evict_done_id = rsp_id of that beat. Acks are accepted in any state and never disturb the FSM or line buffer.
- Simultaneous events: linefill_done_en and evict_done_en may both pulse in the same cycle, with independent ids. Back-to-back acks give back-to-back pulses.
- rsp_err on an ack is reported through proto_err only if it arrives as an ack with rsp_last=0. Otherwise the ack error is not propagated; evict errors are handled downstream.
- Reset mid-operation discards any partial line. No done pulse is ever generated for that line.

Test Plan:
- Line assembly: id 5, four read beats 0x…A0, A1, A2, A3 (last on beat 3), lf_wr_rdy=1 → lf_wr_data = {A3,A2,A1,A0}, lf_wr_id=5, lf_wr_err=0; linefill_done_en pulses one cycle later with id 5; proto_err=0.
- Backpressure: same line with lf_wr_rdy=0 for 6 cycles → lf_wr_vld held and data stable; read beats of id 2 get rsp_rdy=0; an ack id 3 sent meanwhile → evict_done_en/id=3 one cycle later. Release rdy → id 5 retires, then line id 2 proceeds.
- Simultaneous retire: ack id 1 accepted in the same cycle as the lf_wr handshake of id 4 → the next cycle has linefill_done_en=1 (id 4) and evict_done_en=1 (id 1).
- Error accumulation: rsp_err=1 on beat 2 only → lf_wr_err=1. Early rsp_last on beat 1 → proto_err=1, the line still completes after 4 beats.
- Id mismatch: beat 2 carries id 6 while latched id is 0 → proto_err=1, lf_wr_id=0.
- Reset mid-line: rst_n low after 2 beats → all outputs zero, no linefill_done_en; a subsequent full 4-beat line for id 7 assembles correctly.
